// File: rtl/vedic_mul_pipe.sv
// Purpose : pipelined Urdhva-Tiryagbhyam multiplier, per-beat signed/unsigned, 2*WIDTH product.
// Latency : three register stages (operands/magnitudes, quadrant products, recombine), 1 beat/cycle.
// Backpr. : global stall when out_valid && !out_ready; every stage holds and in_ready drops.
module vedic_mul_pipe #(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] prod_low,
   output logic [WIDTH-1:0] prod_high
);

   localparam int H = WIDTH / 2;
   localparam int P = 2 * WIDTH;

   logic             w_stall;
   logic             w_sgn;
   logic             w_neg;
   logic [WIDTH-1:0] w_mag_a;
   logic [WIDTH-1:0] w_mag_b;

   logic             r_s1_vld;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic             r_s1_neg;

   logic [WIDTH-1:0] w_al;
   logic [WIDTH-1:0] w_ah;
   logic [WIDTH-1:0] w_bl;
   logic [WIDTH-1:0] w_bh;

   logic             r_s2_vld;
   logic [WIDTH-1:0] r_s2_ll;
   logic [WIDTH-1:0] r_s2_hl;
   logic [WIDTH-1:0] r_s2_lh;
   logic [WIDTH-1:0] r_s2_hh;
   logic             r_s2_neg;

   logic [P-1:0]     w_t0;
   logic [P-1:0]     w_t1;
   logic [P-1:0]     w_t2;
   logic [P-1:0]     w_t3;
   logic [P-1:0]     w_cs1_s;
   logic [P-1:0]     w_cs1_c;
   logic [P-1:0]     w_cs2_s;
   logic [P-1:0]     w_cs2_c;
   logic [P-1:0]     w_sum;
   logic [P-1:0]     w_res;

   logic             r_s3_vld;
   logic [P-1:0]     r_s3_p;

   // Global stall: only the output register can be blocked, and it freezes the whole pipe.
   always_comb begin
      w_stall  = r_s3_vld && !out_ready;
      in_ready = !w_stall;
   end

   // Sign handling: magnitudes stay WIDTH bits unsigned so |-2^(WIDTH-1)| fits exactly.
   always_comb begin
      w_sgn   = SIGNED_EN && signed_mode;
      w_mag_a = (w_sgn && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      w_mag_b = (w_sgn && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      w_neg   = w_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
   end

   // S1: capture magnitudes and result sign on an accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s1_neg <= 1'b0;
      end else if (!w_stall) begin
         r_s1_vld <= in_valid;
         if (in_valid) begin
            r_s1_a   <= w_mag_a;
            r_s1_b   <= w_mag_b;
            r_s1_neg <= w_neg;
         end
      end
   end

   // Quadrant halves zero-extended to WIDTH so each product lands at its natural width.
   always_comb begin
      w_al = {{(WIDTH-H){1'b0}}, r_s1_a[H-1:0]};
      w_ah = {{(WIDTH-H){1'b0}}, r_s1_a[WIDTH-1:H]};
      w_bl = {{(WIDTH-H){1'b0}}, r_s1_b[H-1:0]};
      w_bh = {{(WIDTH-H){1'b0}}, r_s1_b[WIDTH-1:H]};
   end

   // S2: the four vertical/crosswise half-width partial products.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_s2_ll  <= '0;
         r_s2_hl  <= '0;
         r_s2_lh  <= '0;
         r_s2_hh  <= '0;
         r_s2_neg <= 1'b0;
      end else if (!w_stall) begin
         r_s2_vld <= r_s1_vld;
         r_s2_ll  <= w_al * w_bl;
         r_s2_hl  <= w_ah * w_bl;
         r_s2_lh  <= w_al * w_bh;
         r_s2_hh  <= w_ah * w_bh;
         r_s2_neg <= r_s1_neg;
      end
   end

   // Recombine with two 3:2 carry-save layers and one final adder, then apply the sign.
   // Carries pushed out of the top bit are dropped; the true sum always fits in P bits.
   always_comb begin
      w_t0    = {{WIDTH{1'b0}}, r_s2_ll};
      w_t1    = {{H{1'b0}}, r_s2_hl, {H{1'b0}}};
      w_t2    = {{H{1'b0}}, r_s2_lh, {H{1'b0}}};
      w_t3    = {r_s2_hh, {WIDTH{1'b0}}};
      w_cs1_s = w_t0 ^ w_t1 ^ w_t2;
      w_cs1_c = ((w_t0 & w_t1) | (w_t0 & w_t2) | (w_t1 & w_t2)) << 1;
      w_cs2_s = w_cs1_s ^ w_cs1_c ^ w_t3;
      w_cs2_c = ((w_cs1_s & w_cs1_c) | (w_cs1_s & w_t3) | (w_cs1_c & w_t3)) << 1;
      w_sum   = w_cs2_s + w_cs2_c;
      // Negating zero wraps back to zero, so a zero operand never yields a -0 pattern.
      w_res   = r_s2_neg ? (~w_sum + P'(1)) : w_sum;
   end

   // S3: output register; holds while the consumer is not ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s3_vld <= 1'b0;
         r_s3_p   <= '0;
      end else if (!w_stall) begin
         r_s3_vld <= r_s2_vld;
         r_s3_p   <= w_res;
      end
   end

   // Outputs come straight from the S3 registers.
   always_comb begin
      out_valid = r_s3_vld;
      prod_low  = r_s3_p[WIDTH-1:0];
      prod_high = r_s3_p[P-1:WIDTH];
   end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed bench for vedic_mul_pipe: an 8-bit signed-capable build and a 16-bit unsigned-only build.
// Expected products come from constants or from an integer reference multiply.
module tb_vedic_mul_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 8-bit build, signed mode honoured
   logic       in_valid, in_ready, signed_mode, out_valid, out_ready;
   logic [7:0] a, b, prod_low, prod_high;

   // 16-bit build, signed mode ignored
   logic        in_valid2, in_ready2, signed_mode2, out_valid2, out_ready2;
   logic [15:0] a2, b2, prod_low2, prod_high2;

   vedic_mul_pipe #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .signed_mode(signed_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .prod_low(prod_low), .prod_high(prod_high)
   );

   vedic_mul_pipe #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .signed_mode(signed_mode2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .prod_low(prod_low2), .prod_high(prod_high2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic sm);
      int sx;
      int sy;
      if (sm) begin
         sx = int'($signed(x));
         sy = int'($signed(y));
      end else begin
         sx = int'(x);
         sy = int'(y);
      end
      return 16'(sx * sy);
   endfunction

   task automatic one_beat(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic sm, input logic [15:0] exp);
      a = x; b = y; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk($sformatf("%s_early", tag), 32'(out_valid), 32'd0);
      tick();
      chk($sformatf("%s_vld", tag), 32'(out_valid), 32'd1);
      chk(tag, {16'h0, prod_high, prod_low}, {16'h0, exp});
      tick();
   endtask

   // Streams nbeats random beats; out_ready is low on loop cycles [hold_from, hold_from+hold_len).
   task automatic run_stream(input string tag, input int nbeats, input int hold_from,
                             input int hold_len, output int cycles, output int stalls);
      logic [15:0] q[$];
      logic [15:0] frozen;
      logic [16:0] expv;
      bit          prev_stall;
      bit          accepted;
      int          sent;
      int          got;
      sent = 0; got = 0; cycles = 0; stalls = 0; prev_stall = 1'b0; frozen = '0;
      in_valid = 1'b0;
      while ((got < nbeats) && (cycles < nbeats * 4 + 50)) begin
         out_ready = !((cycles >= hold_from) && (cycles < hold_from + hold_len));
         if ((sent < nbeats) && !in_valid) begin
            a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
            in_valid = 1'b1;
         end
         #1;
         if (out_valid && out_ready) begin
            expv = (q.size() > 0) ? {1'b0, q.pop_front()} : 17'h1_0000;
            chk($sformatf("%s_res%0d", tag, got), {15'h0, 1'b0, prod_high, prod_low}, {15'h0, expv});
            got++;
         end
         if (out_valid && !out_ready) begin
            stalls++;
            chk($sformatf("%s_inrdy_stall", tag), 32'(in_ready), 32'd0);
            if (prev_stall)
               chk($sformatf("%s_frozen", tag), {16'h0, prod_high, prod_low}, {16'h0, frozen});
            frozen     = {prod_high, prod_low};
            prev_stall = 1'b1;
         end else begin
            prev_stall = 1'b0;
         end
         accepted = in_valid && in_ready;
         if (accepted) begin
            q.push_back(model8(a, b, signed_mode));
            sent++;
         end
         tick();
         if (accepted) in_valid = 1'b0;
         cycles++;
      end
      chk($sformatf("%s_count", tag), 32'(got), 32'(nbeats));
      chk($sformatf("%s_leftover", tag), 32'(q.size()), 32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_nodup%0d", tag, i), 32'(out_valid), 32'd0);
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int stl;

      rst = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
      in_valid2 = 1'b0; a2 = '0; b2 = '0; signed_mode2 = 1'b0; out_ready2 = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_prod", {16'h0, prod_high, prod_low}, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst16_out_valid", 32'(out_valid2), 32'd0);

      // 0xFF*0xFF unsigned on the 8-bit build; 0xFFFF*0xFFFF with signed_mode=1 on the unsigned-only build
      a = 8'hFF; b = 8'hFF; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      a2 = 16'hFFFF; b2 = 16'hFFFF; signed_mode2 = 1'b1; in_valid2 = 1'b1;
      tick();
      in_valid = 1'b0; in_valid2 = 1'b0;
      chk("t1_lat1", 32'(out_valid), 32'd0);
      tick();
      chk("t1_lat2", 32'(out_valid), 32'd0);
      tick();
      chk("t1_vld", 32'(out_valid), 32'd1);
      chk("t1_high", 32'(prod_high), 32'hFE);
      chk("t1_low", 32'(prod_low), 32'h01);
      chk("t6_vld", 32'(out_valid2), 32'd1);
      chk("t6_prod", {prod_high2, prod_low2}, 32'hFFFE_0001);
      tick();
      chk("t1_drain", 32'(out_valid), 32'd0);

      // Unsigned-only build: top operand bit set must not be treated as a sign
      a2 = 16'h8000; b2 = 16'h0003; signed_mode2 = 1'b1; in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      tick();
      tick();
      chk("t6_8000x3", {prod_high2, prod_low2}, 32'h0001_8000);

      // Directed signed/unsigned corner products
      one_beat("t2_s_m128sq",   8'h80, 8'h80, 1'b1, 16'h4000);
      one_beat("t2_s_m128x1",   8'h80, 8'h01, 1'b1, 16'hFF80);
      one_beat("t2_s_zero_neg", 8'h00, 8'h85, 1'b1, 16'h0000);
      one_beat("t2_u_80x80",    8'h80, 8'h80, 1'b0, 16'h4000);
      one_beat("t2_s_m1xm1",    8'hFF, 8'hFF, 1'b1, 16'h0001);
      one_beat("t2_s_127xm127", 8'h7F, 8'h81, 1'b1, 16'hC0FF);
      one_beat("t2_s_m1x1",     8'hFF, 8'h01, 1'b1, 16'hFFFF);
      one_beat("t2_u_ffx01",    8'hFF, 8'h01, 1'b0, 16'h00FF);

      // 256 back-to-back mixed-mode beats at full throughput
      run_stream("t3", 256, 100000, 0, cyc, stl);
      chk("t3_cycles", 32'(cyc), 32'd259);
      chk("t3_stalls", 32'(stl), 32'd0);

      // Backpressure: three beats fill the pipe, the fourth waits out a 6-cycle stall
      run_stream("t4", 4, 2, 7, cyc, stl);
      chk("t4_stalls", 32'(stl), 32'd6);
      chk("t4_cycles", 32'(cyc), 32'd13);

      // Reset with three beats in flight
      out_ready = 1'b1; signed_mode = 1'b0;
      a = 8'd3; b = 8'd5; in_valid = 1'b1;
      tick();
      a = 8'd7; b = 8'd9;
      tick();
      a = 8'd11; b = 8'd13;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t5_pre_vld", 32'(out_valid), 32'd1);
      chk("t5_pre_prod", {16'h0, prod_high, prod_low}, 32'd15);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_vld", 32'(out_valid), 32'd0);
      chk("t5_rst_prod", {16'h0, prod_high, prod_low}, 32'h0);
      chk("t5_rst_inrdy", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("t5_no_stale%0d", i), 32'(out_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
